// File: rtl/accum_pkg.sv
// Shared types and default sizes for the accumulate sequencer slice.
package accum_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {IDLE, ACCEPT, ADD, DONE} state_t;
endpackage

// File: rtl/load_register.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
module load_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/accum_sequencer.sv
// Sequences operand capture and accumulation of N operands; reports sum,
// sticky carry, a done pulse and an error pulse for a zero count.
module accum_sequencer
  import accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t           state;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] op, acc, acc_d;
  logic [WIDTH:0]   sum;
  logic             start_ok, op_load, acc_load;

  assign start_ok  = (state == IDLE) && start && (count != '0);
  assign din_ready = (state == ACCEPT);
  assign op_load   = din_ready && din_valid;
  assign sum       = {1'b0, acc} + {1'b0, op};
  // Accumulator is cleared on an accepted start and written once per ADD.
  assign acc_load  = start_ok || (state == ADD);
  assign acc_d     = start_ok ? '0 : sum[WIDTH-1:0];
  assign result    = acc;

  load_register #(.WIDTH(WIDTH)) u_op (
    .clk(clk), .reset(reset), .load(op_load), .d(din), .q(op)
  );

  load_register #(.WIDTH(WIDTH)) u_acc (
    .clk(clk), .reset(reset), .load(acc_load), .d(acc_d), .q(acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      carry_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              rem       <= count;
              carry_out <= 1'b0;
              busy      <= 1'b1;
              state     <= ACCEPT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (din_valid) state <= ADD;
        end
        ADD: begin
          carry_out <= carry_out | sum[WIDTH];
          rem       <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ACCEPT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_sequencer.sv
// Scoreboard bench: driver pushes expected sums, negedge monitor checks done/err.
module tb_accum_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, start, din_valid;
  logic [CW-1:0] count;
  logic [W-1:0]  din;
  logic          din_ready, carry_out, busy, done, err;
  logic [W-1:0]  result;

  accum_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .result(result),
    .carry_out(carry_out), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           n;
    int           start_cyc;
    bit           timed;
  } exp_t;

  int           tests = 0, fails = 0, cyc = 0;
  exp_t         exp_q[$];
  logic [W-1:0] err_q[$];
  logic [W-1:0] ops_q[$];
  int           gaps_q[$];
  logic [W-1:0] last_res = '0;
  int           xfers = 0;
  logic         prev_done = 1'b0, prev_err = 1'b0;
  exp_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts transfers and checks every done/err pulse against the queues.
  always @(negedge clk) begin
    if (reset) begin
      xfers     = 0;
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (din_valid && din_ready) xfers++;
      if (prev_done) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
      end
      if (prev_err) chk("err_one_cycle", err, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 required no pending run");
        end else begin
          mon_e = exp_q.pop_front();
          chk("result", result, mon_e.res);
          chk("carry_out", carry_out, mon_e.c);
          chk("transfers", xfers, mon_e.n);
          chk("busy_at_done", busy, 1);
          if (mon_e.timed) chk("latency", cyc - mon_e.start_cyc, 2 * mon_e.n + 1);
        end
        xfers = 0;
      end
      if (err) begin
        if (err_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_err: got err=1 required no pending zero-count start");
        end else begin
          chk("err_result_hold", result, err_q.pop_front());
          chk("err_busy", busy, 0);
        end
      end
      prev_done = done;
      prev_err  = err;
    end
  end

  task automatic send(input logic [W-1:0] v, input int gap, input bit poke);
    int t = 0;
    while (!din_ready && t < 40) begin step(); t++; end
    if (!din_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got din_ready=0 required 1 within 40 cycles");
      return;
    end
    for (int g = 0; g < gap; g++) begin
      if (poke && g == 0) begin start = 1'b1; count = CW'(9); end
      step();
      start = 1'b0;
      chk("ready_in_gap", din_ready, 1);
    end
    din_valid = 1'b1;
    din       = v;
    step();
    din_valid = 1'b0;
    din       = 8'($urandom);
  endtask

  // Reference: final value is the plain total mod 2^W; the sticky carry is set
  // exactly when the unwrapped total reaches 2^W.
  task automatic run(input int n, input int gap_lo, input int gap_hi, input bit poke);
    exp_t e;
    int   total = 0;
    int   t = 0;
    while (ops_q.size() < n) ops_q.push_back(8'($urandom));
    while (gaps_q.size() < n) gaps_q.push_back($urandom_range(gap_hi, gap_lo));
    if (poke && gaps_q[0] == 0) gaps_q[0] = 1;
    for (int i = 0; i < n; i++) total += int'(ops_q[i]);
    e.res       = W'(total % 256);
    e.c         = (total > 255);
    e.n         = n;
    e.timed     = 1'b1;
    for (int i = 0; i < n; i++) if (gaps_q[i] != 0) e.timed = 1'b0;
    start       = 1'b1;
    count       = CW'(n);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    step();
    start = 1'b0;
    for (int i = 0; i < n; i++) send(ops_q[i], gaps_q[i], poke && i == 0);
    ops_q.delete();
    gaps_q.delete();
    while (exp_q.size() != 0 && t < 30) begin step(); t++; end
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done, required done after %0d operands", n);
      exp_q.delete();
    end
    last_res = e.res;
  endtask

  task automatic zero_count();
    start = 1'b1;
    count = '0;
    err_q.push_back(last_res);
    step();
    start = 1'b0;
    chk("busy_on_err", busy, 0);
    step();
    step();
    chk("err_seen", err_q.size(), 0);
    err_q.delete();
  endtask

  task automatic check_zeroed(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_carry"}, carry_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ready"}, din_ready, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; count = '0; din = '0; din_valid = 1'b0;
    repeat (3) step();
    check_zeroed("reset");
    reset = 1'b0;
    step();

    // Basic sum
    ops_q = '{8'h10, 8'h20, 8'h30};
    gaps_q = '{0, 0, 0};
    run(3, 0, 0, 1'b0);
    // Overflow then sticky carry cleared by next start
    ops_q = '{8'hF0, 8'h20};
    run(2, 0, 0, 1'b0);
    ops_q = '{8'h05};
    run(1, 0, 0, 1'b0);
    // Backpressure
    ops_q = '{8'h01, 8'h02};
    gaps_q = '{5, 3};
    run(2, 0, 0, 1'b0);
    // Zero count keeps previous result
    zero_count();
    // Reset mid-run
    start = 1'b1; count = CW'(4);
    step();
    start = 1'b0;
    send(8'h11, 0, 1'b0);
    send(8'h22, 0, 1'b0);
    reset = 1'b1;
    step();
    check_zeroed("midreset");
    reset = 1'b0;
    last_res = '0;
    ops_q = '{8'h7F};
    run(1, 0, 0, 1'b0);
    // start ignored while busy
    run(2, 1, 2, 1'b1);

    for (int r = 0; r < 25; r++) begin
      bit poke;
      poke = ($urandom_range(3, 0) == 0);
      run($urandom_range(15, 1), poke ? 1 : 0, 2, poke);
      if ($urandom_range(4, 0) == 0) zero_count();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish before 300000");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
- Controller that sequences the 8-bit operand register, adder and result register to sum a stream of N operands.
- Accepts a start command with an operand count, then pulls operands over a valid/ready input and accumulates them.
- Reports the sum, a sticky carry and a one-cycle done pulse.
- Sits between the host/testbench stimulus logic and the adder datapath; it is the only writer of the operand and accumulator registers.

Parameters:
- WIDTH, 8, datapath width of operands, accumulator and result.
- CNT_W, 4, width of the operand-count field; max operands = 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- count  in  CNT_W  number of operands, sampled with start.
- din  in  WIDTH  operand data.
- din_valid  in  1  din holds a valid operand.
- din_ready  out  1  sequencer accepts din this cycle.
- result  out  WIDTH  accumulator value; holds the final sum after done.
- carry_out  out  1  sticky OR of all adder carries in the current run.
- busy  out  1  high from the start-accept edge until done drops.
- done  out  1  one-cycle pulse: result/carry_out are final.
- err  out  1  one-cycle pulse: start received with count==0.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state is updated on the rising edge of clk.
- Reset (any state, including mid-run):
  - state=IDLE.
  - result=0, carry_out=0, busy=0, done=0, err=0, din_ready=0.
  - Operand register=0 and remaining count=0.
- States are IDLE, ACCEPT, ADD and DONE.
- IDLE:
  - din_ready=0.
  - start=1 and count!=0: clear accumulator and carry_out to 0, load rem=count, go to ACCEPT, busy=1.
  - start=1 and count==0: err=1 for the next cycle, stay in IDLE, result and carry_out unchanged.
- ACCEPT:
  - din_ready=1 (combinational from state).
  - A transfer happens when din_valid and din_ready are both high at a clock edge: capture din into the operand register and go to ADD.
  - No transfer: stay in ACCEPT indefinitely. There is no timeout.
- ADD:
  - din_ready=0.
  - Form the (WIDTH+1)-bit sum = {0,acc} + {0,op}.
  - acc <= sum[WIDTH-1:0], carry_out <= carry_out | sum[WIDTH], rem <= rem-1.
  - Old rem==1: go to DONE. Otherwise go to ACCEPT.
- DONE:
  - done=1 for exactly one cycle, busy stays 1, then go to IDLE with busy=0.
- Wrap-around is modulo 2^WIDTH; overflow is reported only through carry_out.
- Latency with din_valid held high: 2 cycles per operand. done is high in the cycle following edge 2N after the start-accept edge.
- start is ignored in ACCEPT, ADD and DONE; there is no restart mid-run.
- start in the cycle immediately after done (IDLE) is legal.
- result and carry_out hold their last values in IDLE until the next accepted start clears them.
- din and din_valid are don't-care outside ACCEPT.
- din_valid may drop at any time before a transfer without effect.

Decomposition:
- Package accum_pkg holds:
  - the state enum {IDLE, ACCEPT, ADD, DONE};
  - default WIDTH and CNT_W constants.
- Sub-module load_register: WIDTH-bit register with synchronous active-high reset and a load enable. It is instantiated twice: operand register and accumulator.
- FSM, counter and carry logic stay in accum_sequencer.

Test Plan:
- Basic sum: reset, then start with count=3; stream 0x10, 0x20, 0x30 with din_valid held high -> done pulse after edge 6, result=0x60, carry_out=0, busy low one cycle later.
- Overflow: count=2, operands 0xF0 then 0x20 -> result=0x10, carry_out=1. A following run with count=1, operand 0x05 -> result=0x05, carry_out=0 (sticky carry cleared by start).
- Backpressure: count=2, din_valid low for 5 cycles in ACCEPT, then 0x01, gap of 3 cycles, then 0x02 -> din_ready stays high throughout the gaps, exactly 2 transfers occur, result=0x03.
- Illegal count: start with count=0 -> err pulses for one cycle, busy stays 0, result keeps its previous value.
- Reset mid-run: count=4, reset asserted after the second transfer -> next cycle all outputs are 0 and state is IDLE. A fresh count=1, operand 0x7F -> result=0x7F.
- start while busy: pulse start with count=9 during ACCEPT of a count=2 run -> ignored; the run finishes after 2 operands with the correct sum.
